// File: rtl/alu4_driver.sv
// Command FIFO + sequencer that drives an alu4 instance and returns its result/flags as a valid/ready response.
// Optional STICKY_FLAGS_EN adds sticky_clr / sticky_flags (OR-accumulated flags across captures).
module alu4_driver #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [3:0]       alu_n1,
  output logic [3:0]       alu_n2,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_out,
  input  logic             alu_carryf,
  input  logic             alu_zerof,
  input  logic             alu_negativef,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
`ifdef STICKY_FLAGS_EN
  input  logic             sticky_clr,
  output logic [2:0]       sticky_flags,
`endif
  output logic [1:0]       o_dbg_state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int CNT_W = $clog2(SETTLE + 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a held response keeps its payload stable.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [9:0]         r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic               r_rdy_en;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_alu_n1;
  logic [3:0]         r_alu_n2;
  logic [1:0]         r_alu_op;
  logic               r_rsp_valid;
  logic [3:0]         r_rsp_result;
  logic [2:0]         r_rsp_flags;
  logic [TAG_W-1:0]   r_rsp_tag;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_capture;
  logic               w_accept;
  logic [9:0]         w_head;
  logic [2:0]         w_flags;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // r_rdy_en keeps cmd_ready low until the first edge after reset is released.
  assign w_push  = cmd_valid & cmd_ready;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_flags = {alu_carryf, alu_zerof, alu_negativef};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (r_cnt == CNT_W'(1)) begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: if (rsp_ready) begin
        w_accept    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rdy_en     <= 1'b0;
      r_cnt        <= '0;
      r_alu_n1     <= '0;
      r_alu_n2     <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_tag    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_alu_op <= w_head[9:8];
        r_alu_n1 <= w_head[7:4];
        r_alu_n2 <= w_head[3:0];
        r_cnt    <= CNT_W'(SETTLE);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= alu_out;
        r_rsp_flags  <= w_flags;
      end
      if (w_accept) begin
        r_rsp_valid <= 1'b0;
        r_rsp_tag   <= r_rsp_tag + TAG_W'(1);
      end
    end
  end

`ifdef STICKY_FLAGS_EN
  logic [2:0] r_sticky;
  // A capture on the same edge as a clear restarts accumulation from the new flags.
  always_ff @(posedge clk) begin
    if (rst)             r_sticky <= '0;
    else if (w_capture)  r_sticky <= sticky_clr ? w_flags : (r_sticky | w_flags);
    else if (sticky_clr) r_sticky <= '0;
  end
  assign sticky_flags = r_sticky;
`endif

  assign cmd_ready   = r_rdy_en & ~w_full;
  assign alu_n1      = r_alu_n1;
  assign alu_n2      = r_alu_n2;
  assign alu_op      = r_alu_op;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_flags   = r_rsp_flags;
  assign rsp_tag     = r_rsp_tag;
  assign busy        = (r_state != S_IDLE) | ~w_empty;
  assign o_dbg_state = r_state;

endmodule
